// File: rtl/codma_task_fetch.sv
// codma_task_fetch: descriptor reader for the codma engine.
// Fetches, validates and issues descriptors, then writes status.
module codma_task_fetch #(
    parameter int MEM_DEPTH   = 32,
    parameter int MEM_WIDTH   = 8,
    parameter int LINK_OFFSET = 32
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [31:0] task_pointer_i,
    input  logic [31:0] status_pointer_i,
    output logic        busy_o,
    output logic        rd_req_o,
    output logic [31:0] rd_addr_o,
    input  logic        rd_gnt_i,
    input  logic        rd_valid_i,
    input  logic [63:0] rd_data_i,
    output logic        wr_req_o,
    output logic [31:0] wr_addr_o,
    output logic [63:0] wr_data_o,
    input  logic        wr_gnt_i,
    output logic        task_valid_o,
    input  logic        task_ready_i,
    output logic [1:0]  task_type_o,
    output logic [31:0] src_addr_o,
    output logic [31:0] dst_addr_o,
    output logic [31:0] len_bytes_o,
    input  logic        eng_done_i,
    input  logic        eng_error_i,
    output logic        done_o,
    output logic        error_o
);

    typedef enum logic [3:0] {
        IDLE,
        RD0,
        RD0_WAIT,
        RD1,
        RD1_WAIT,
        CHECK,
        ISSUE,
        EXEC,
        STATUS,
        DONE
    } state_e;

    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH * MEM_WIDTH);
    localparam logic [31:0] WORD_OFS  = 32'(MEM_WIDTH);
    localparam logic [31:0] LINK_OFS  = 32'(LINK_OFFSET);

    state_e      state_q, state_d;
    logic [31:0] task_ptr_q, task_ptr_d;
    logic [31:0] stat_ptr_q, stat_ptr_d;
    logic [31:0] cur_ptr_q, cur_ptr_d;
    logic        link_q, link_d;
    logic        err_q, err_d;
    logic [63:0] w0_q, w0_d;
    logic [63:0] w1_q, w1_d;

    logic [31:0] d_type;
    logic [31:0] d_src;
    logic [31:0] d_dst;
    logic [31:0] d_len;
    logic [32:0] src_end;
    logic [32:0] dst_end;
    logic        desc_bad;

    assign d_type  = w0_q[31:0];
    assign d_src   = w0_q[63:32];
    assign d_dst   = w1_q[31:0];
    assign d_len   = w1_q[63:32];
    assign src_end = {1'b0, d_src} + {1'b0, d_len};
    assign dst_end = {1'b0, d_dst} + {1'b0, d_len};

    assign task_type_o = d_type[1:0];
    assign src_addr_o  = d_src;
    assign dst_addr_o  = d_dst;
    assign len_bytes_o = d_len;
    assign error_o     = err_q;

    // Descriptor validation on the captured words
    always_comb begin
        desc_bad = 1'b0;
        if (cur_ptr_q[2:0] != 3'd0)
            desc_bad = 1'b1;
        if (d_type > 32'd2)
            desc_bad = 1'b1;
        if (link_q && d_type == 32'd2)
            desc_bad = 1'b1;
        if (d_len == 32'd0)
            desc_bad = 1'b1;
        if (d_type == 32'd0 && d_len[2:0] != 3'd0)
            desc_bad = 1'b1;
        if ((d_type == 32'd1 || d_type == 32'd2)
            && d_len[4:0] != 5'd0)
            desc_bad = 1'b1;
        if (src_end > MEM_BYTES || dst_end > MEM_BYTES)
            desc_bad = 1'b1;
    end

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Datapath registers: pointers, link phase, error, words
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            task_ptr_q <= '0;
            stat_ptr_q <= '0;
            cur_ptr_q  <= '0;
            link_q     <= 1'b0;
            err_q      <= 1'b0;
            w0_q       <= '0;
            w1_q       <= '0;
        end else begin
            task_ptr_q <= task_ptr_d;
            stat_ptr_q <= stat_ptr_d;
            cur_ptr_q  <= cur_ptr_d;
            link_q     <= link_d;
            err_q      <= err_d;
            w0_q       <= w0_d;
            w1_q       <= w1_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        task_ptr_d = task_ptr_q;
        stat_ptr_d = stat_ptr_q;
        cur_ptr_d  = cur_ptr_q;
        link_d     = link_q;
        err_d      = err_q;
        w0_d       = w0_q;
        w1_d       = w1_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    task_ptr_d = task_pointer_i;
                    stat_ptr_d = status_pointer_i;
                    cur_ptr_d  = task_pointer_i;
                    link_d     = 1'b0;
                    err_d      = 1'b0;
                    state_d    = RD0;
                end
            end
            RD0: begin
                if (rd_gnt_i) begin
                    if (rd_valid_i) begin
                        w0_d    = rd_data_i;
                        state_d = RD1;
                    end else begin
                        state_d = RD0_WAIT;
                    end
                end
            end
            RD0_WAIT: begin
                if (rd_valid_i) begin
                    w0_d    = rd_data_i;
                    state_d = RD1;
                end
            end
            RD1: begin
                if (rd_gnt_i) begin
                    if (rd_valid_i) begin
                        w1_d    = rd_data_i;
                        state_d = CHECK;
                    end else begin
                        state_d = RD1_WAIT;
                    end
                end
            end
            RD1_WAIT: begin
                if (rd_valid_i) begin
                    w1_d    = rd_data_i;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (desc_bad) begin
                    err_d   = 1'b1;
                    state_d = STATUS;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (task_ready_i)
                    state_d = EXEC;
            end
            EXEC: begin
                if (eng_done_i) begin
                    if (eng_error_i) begin
                        err_d   = 1'b1;
                        state_d = STATUS;
                    end else if (d_type == 32'd2 && !link_q) begin
                        cur_ptr_d = task_ptr_q + LINK_OFS;
                        link_d    = 1'b1;
                        state_d   = RD0;
                    end else begin
                        state_d = STATUS;
                    end
                end
            end
            STATUS: begin
                if (wr_gnt_i)
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        busy_o       = 1'b0;
        rd_req_o     = 1'b0;
        rd_addr_o    = '0;
        wr_req_o     = 1'b0;
        wr_addr_o    = '0;
        wr_data_o    = '0;
        task_valid_o = 1'b0;
        done_o       = 1'b0;
        unique case (state_q)
            RD0: begin
                busy_o    = 1'b1;
                rd_req_o  = 1'b1;
                rd_addr_o = cur_ptr_q;
            end
            RD1: begin
                busy_o    = 1'b1;
                rd_req_o  = 1'b1;
                rd_addr_o = cur_ptr_q + WORD_OFS;
            end
            RD0_WAIT, RD1_WAIT, CHECK, EXEC: begin
                busy_o = 1'b1;
            end
            ISSUE: begin
                busy_o       = 1'b1;
                task_valid_o = 1'b1;
            end
            STATUS: begin
                busy_o    = 1'b1;
                wr_req_o  = 1'b1;
                wr_addr_o = stat_ptr_q;
                wr_data_o = {63'd0, err_q};
            end
            DONE: done_o = 1'b1;
            default: busy_o = 1'b0;
        endcase
    end

endmodule
